// File: rtl/midi_note_tracker.sv
// midi_note_tracker: MIDI byte-stream parser feeding a monophonic last-note-priority
// note stack for one channel; presents the sounding note, velocity and gate.
module midi_note_tracker #(
  parameter logic [3:0]  CHANNEL     = 4'd0,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic [7:0] note,
  output logic [6:0] velocity,
  output logic       gate,
  output logic       note_valid,
  output logic       overflow
);
  localparam int W = 14;
  localparam int D = STACK_DEPTH;
  typedef enum logic [1:0] {IDLE, SKIP, WAIT_D1, WAIT_D2} state_t;
  state_t state;
  logic [7:0] status;
  logic [6:0] d1;
  logic [D*W-1:0] stk, stk_up, r_stk, p_stk, n_stk;
  logic [D-1:0] vld, vld_up, r_vld, p_vld, n_vld;
  logic is_sys, is_stat, is_data, two_byte, exec, do_push, do_rem, do_clr, m, n_gate;
  logic [6:0] key, vel_in, n_note, n_vel;
  assign is_data  = byte_valid && !byte_data[7];
  assign is_sys   = byte_valid && byte_data[7:3] == 5'b11110;
  assign is_stat  = byte_valid && byte_data[7] && byte_data[7:4] != 4'hF;
  assign two_byte = status[7:4] != 4'hC && status[7:4] != 4'hD;
  assign exec     = is_data && status[3:0] == CHANNEL &&
                    ((state == WAIT_D1 && !two_byte) || state == WAIT_D2);
  assign key      = state == WAIT_D2 ? d1 : byte_data[6:0];
  assign vel_in   = byte_data[6:0];
  assign do_push  = exec && status[7:4] == 4'h9 && vel_in != 7'd0;
  assign do_rem   = exec && (status[7:4] == 4'h8 || (status[7:4] == 4'h9 && vel_in == 7'd0));
  assign do_clr   = exec && status[7:4] == 4'hB && key == 7'd123;
  // Entry 0 is the top; removing a match pulls every older entry up one slot.
  always_comb begin
    stk_up = stk >> W;
    vld_up = vld >> 1;
    m = 1'b0;
    r_stk = stk;
    r_vld = vld;
    for (int i = 0; i < D; i++) begin
      m = m | (vld[i] && stk[i*W+7 +: 7] == key);
      r_stk[i*W +: W] = m ? stk_up[i*W +: W] : stk[i*W +: W];
      r_vld[i] = m ? vld_up[i] : vld[i];
    end
  end
  assign p_stk  = {r_stk[(D-1)*W-1:0], key, vel_in};
  assign p_vld  = {r_vld[D-2:0], 1'b1};
  assign n_stk  = do_push ? p_stk : do_rem ? r_stk : stk;
  assign n_vld  = do_push ? p_vld : do_rem ? r_vld : do_clr ? '0 : vld;
  assign n_gate = n_vld[0];
  assign n_note = n_gate ? n_stk[W-1 -: 7] : note[6:0];
  assign n_vel  = n_gate ? n_stk[6:0] : velocity;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      status     <= '0;
      d1         <= '0;
      stk        <= '0;
      vld        <= '0;
      note       <= '0;
      velocity   <= '0;
      gate       <= 1'b0;
      note_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (is_sys) begin
        state  <= SKIP;
        status <= '0;
      end else if (is_stat) begin
        state  <= WAIT_D1;
        status <= byte_data;
      end else if (is_data) begin
        if (state == WAIT_D1) begin
          d1 <= byte_data[6:0];
          if (two_byte) state <= WAIT_D2;
        end else if (state == WAIT_D2) begin
          state <= WAIT_D1;
        end
      end
      stk        <= n_stk;
      vld        <= n_vld;
      note       <= {1'b0, n_note};
      velocity   <= n_vel;
      gate       <= n_gate;
      note_valid <= {n_note, n_vel, n_gate} != {note[6:0], velocity, gate};
      overflow   <= do_push && r_vld[D-1];
    end
  end
endmodule

// File: tb/tb_midi_note_tracker.sv
// tb_midi_note_tracker: directed test-plan steps plus random byte streams checked
// against a queue-based reference model of the parser and note stack.
module tb_midi_note_tracker;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0, byte_valid = 1'b0;
  logic [7:0] byte_data = '0;
  logic [7:0] note;
  logic [6:0] velocity;
  logic gate, note_valid, overflow;
  int n_asserts = 0, n_fail = 0;
  logic [13:0] q[$];
  logic [7:0] m_st;
  logic [6:0] m_d[$];
  logic [7:0] e_note;
  logic [6:0] e_vel;
  logic e_gate, e_nv, e_ov;

  midi_note_tracker #(.CHANNEL(4'd0), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .byte_data(byte_data), .byte_valid(byte_valid),
    .note(note), .velocity(velocity), .gate(gate), .note_valid(note_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".note"}, note, e_note);
    chk({tag, ".vel"}, {1'b0, velocity}, {1'b0, e_vel});
    chk({tag, ".gate"}, {7'd0, gate}, {7'd0, e_gate});
    chk({tag, ".nv"}, {7'd0, note_valid}, {7'd0, e_nv});
    chk({tag, ".ovf"}, {7'd0, overflow}, {7'd0, e_ov});
  endtask

  task automatic m_remove(input logic [6:0] a);
    for (int i = 0; i < q.size(); i++)
      if (q[i][13:7] == a) begin
        q.delete(i);
        break;
      end
  endtask

  task automatic m_exec(input logic [7:0] st, input logic [6:0] a, input logic [6:0] v);
    if (st[3:0] != 4'd0) return;
    if (st[7:4] == 4'h9 && v != 0) begin
      m_remove(a);
      if (q.size() == DEPTH) begin
        q.delete(0);
        e_ov = 1'b1;
      end
      q.push_back({a, v});
    end else if (st[7:4] == 4'h8 || st[7:4] == 4'h9) begin
      m_remove(a);
    end else if (st[7:4] == 4'hB && a == 7'd123) begin
      q.delete();
    end
  endtask

  task automatic model_step(input logic valid, input logic [7:0] b);
    logic [7:0] pn;
    logic [6:0] pv;
    logic pg;
    int need;
    pn = e_note; pv = e_vel; pg = e_gate;
    e_ov = 1'b0;
    if (valid) begin
      if (b >= 8'hF8) begin
      end else if (b >= 8'hF0) begin
        m_st = 8'h00;
        m_d.delete();
      end else if (b >= 8'h80) begin
        m_st = b;
        m_d.delete();
      end else if (m_st != 8'h00) begin
        m_d.push_back(b[6:0]);
        need = (m_st[7:4] == 4'hC || m_st[7:4] == 4'hD) ? 1 : 2;
        if (m_d.size() == need) begin
          m_exec(m_st, m_d[0], need == 2 ? m_d[1] : 7'd0);
          m_d.delete();
        end
      end
    end
    e_gate = q.size() > 0;
    if (e_gate) begin
      e_note = {1'b0, q[q.size()-1][13:7]};
      e_vel = q[q.size()-1][6:0];
    end
    e_nv = {pn, pv, pg} != {e_note, e_vel, e_gate};
  endtask

  task automatic cycle(input logic valid, input logic [7:0] b);
    byte_valid = valid;
    byte_data = b;
    @(posedge clk);
    model_step(valid, b);
    #1;
    byte_valid = 1'b0;
    chk_all("cyc");
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, b);
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    q.delete(); m_d.delete();
    m_st = 0; e_note = 0; e_vel = 0; e_gate = 0; e_nv = 0; e_ov = 0;
    chk_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    logic [3:0] hi;
    logic [3:0] his [9] = '{4'h8, 4'h9, 4'h9, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
    do_reset();
    send(8'h90); send(8'h3C); send(8'h64);
    chk("tp1.note", note, 8'h3C);
    chk("tp1.vel", {1'b0, velocity}, 8'h64);
    chk("tp1.nv", {7'd0, note_valid}, 8'd1);
    cycle(1'b0, 8'h00);
    chk("tp1.nv_off", {7'd0, note_valid}, 8'd0);
    do_reset();
    send(8'h90); send(8'h3C); send(8'h64); send(8'h40); send(8'h50);
    chk("tp2.note40", note, 8'h40);
    send(8'h40); send(8'h00);
    chk("tp2.back", {note, 1'b0, velocity}, {8'h3C, 8'h64});
    do_reset();
    send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h64);
    chk("tp3.rt", {note, 1'b0, velocity}, {8'h3C, 8'h64});
    do_reset();
    send(8'h91); send(8'h3C); send(8'h64);
    send(8'hF0); send(8'h3C); send(8'h64); send(8'hF7);
    chk("tp4.gate", {7'd0, gate}, 8'd0);
    do_reset();
    send(8'h90);
    for (int n = 60; n < 64; n++) begin send(8'(n)); send(8'h40); end
    send(8'd64); send(8'h40);
    chk("tp5.ovf", {7'd0, overflow}, 8'd1);
    for (int n = 64; n > 60; n--) begin send(8'(n)); send(8'h00); end
    chk("tp5.gate", {7'd0, gate}, 8'd0);
    send(8'h80); send(8'd60); send(8'h00);
    chk("tp5.nopulse", {7'd0, note_valid}, 8'd0);
    do_reset();
    send(8'h90); send(8'd60); send(8'h50); send(8'd61); send(8'h51); send(8'd62); send(8'h52);
    send(8'hB0); send(8'h7B); send(8'h00);
    chk("tp6.clr", {7'd0, gate, note_valid}, 8'd1);
    send(8'h90); send(8'h3C);
    do_reset();
    send(8'h64);
    chk("tp6.idle", {7'd0, gate}, 8'd0);
    for (int k = 0; k < 4000; k++) begin
      r = $urandom_range(0, 99);
      hi = his[$urandom_range(0, 8)];
      if ($urandom_range(0, 4) == 0) cycle(1'b0, 8'h00);
      else if (r < 6) send(8'hF8 + 8'($urandom_range(0, 7)));
      else if (r < 9) send(8'hF0 + 8'($urandom_range(0, 7)));
      else if (r < 25) send({hi, ($urandom_range(0, 3) == 0) ? 4'd1 : 4'd0});
      else if (r < 27) send(8'd123);
      else if (r < 45) send(8'h00);
      else send(8'(60 + $urandom_range(0, 6)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/midi_note_tracker.md
Name: midi_note_tracker

Overview:
Upstream stage of the MIDI player. Parses the raw MIDI byte stream from the UART receiver: status bytes, running status, realtime and system filtering. Maintains a monophonic last-note-priority note stack for one MIDI channel. Presents the currently sounding note, its velocity and a gate, so the player's note input can be driven directly.

Parameters:
CHANNEL, 0, MIDI channel (0-15) accepted; voice messages on other channels ignored
STACK_DEPTH, 4, held-note stack entries (2..8)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
byte_data  input  8  received MIDI byte
byte_valid  input  1  byte_data valid this cycle; may be high on consecutive cycles
note  output  8  sounding note number; bit 7 always 0; drives player midi_data
velocity  output  7  velocity of sounding note
gate  output  1  1 while stack non-empty
note_valid  output  1  one-cycle pulse when note, velocity or gate changes
overflow  output  1  one-cycle pulse when a push evicts the oldest entry

Behaviour:
- Reset (async assert, sync release): state IDLE, running status cleared, stack empty, all outputs 0. Reset mid-message discards the partial message.
- byte_data is sampled only when byte_valid=1.
- Realtime bytes 0xF8-0xFF: ignored in every state. State, running status and partial data are untouched.
- System common 0xF0-0xF7: clear running status, go to SKIP.
- Channel status 0x80-0xEF: latch as running status, go to WAIT_D1. This aborts any partial message.
- Data counts: 0x8n, 0x9n, 0xAn, 0xBn, 0xEn take 2 data bytes; 0xCn, 0xDn take 1.
- FSM states:
  - IDLE: data byte discarded.
  - SKIP: data bytes discarded until next status.
  - WAIT_D1: latch d1. Go to WAIT_D2 for 2-byte messages. For 1-byte messages, execute and stay in WAIT_D1.
  - WAIT_D2: latch d2, execute, return to WAIT_D1 (running status).
- Execute only when status low nibble == CHANNEL:
  - 0x9n with d2>0: push(d1, d2).
  - 0x8n, or 0x9n with d2=0: remove(d1).
  - 0xBn with d1=123 (all notes off): clear stack.
  - All other messages: no action.
- Stack:
  - Entries hold {note, velocity}; top = most recent.
  - push: if the note is already present, remove it first, then place it on top with the new velocity. If the stack is full, discard the bottom entry and pulse overflow in the same cycle as note_valid.
  - remove: delete the matching entry and compact order. A note not present is a no-op.
  - clear: empty the stack.
- Outputs:
  - Registered. They update on the clock edge after the cycle carrying the final data byte; latency is 1 cycle.
  - note/velocity = top entry. When the stack is empty, note and velocity hold their last values and gate=0.
  - note_valid pulses only if {note, velocity, gate} differs from the previous value. Example: removing a non-top note gives no pulse.
- One operation per accepted byte. Back-to-back bytes are fully supported with no stall and no ready signal.

Test Plan:
- Reset, then 0x90 0x3C 0x64 -> after 1 cycle: note=0x3C, velocity=0x64, gate=1, note_valid pulse 1 cycle.
- Running status: 0x90 0x3C 0x64 0x40 0x50 0x40 0x00 -> top goes 0x3C, then 0x40, then back to 0x3C with velocity 0x64, gate=1; three note_valid pulses.
- Realtime interleave: 0x90 0xF8 0x3C 0xFE 0x64 -> same result as without 0xF8/0xFE.
- Wrong channel and sysex: 0x91 0x3C 0x64, then 0xF0 0x3C 0x64 0xF7 -> no output change, gate=0, no pulses.
- Overflow at STACK_DEPTH=4: push notes 60, 61, 62, 63, 64 -> overflow pulse on the fifth push. Release 64, 63, 62, 61 -> gate=0 after 61 (60 was evicted). A subsequent 0x80 60 0x00 causes no pulse.
- Control and reset: hold 3 notes, send 0xB0 0x7B 0x00 -> gate=0 with one pulse. Then 0x90 0x3C, assert rst_n low before the velocity byte -> outputs 0. After release, 0x64 alone is discarded (IDLE).
